// File: rtl/imem_fetch_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module : imem_fetch_ctrl                                          |
// | Brief  : nRisc fetch sequencer, 1/2-byte assembly, branch, HALT   |
// | Rev    : 1.0  initial release                                     |
// +------------------------------------------------------------------+
module imem_fetch_ctrl #(
  parameter logic [7:0] START_PC   = 8'h00,
  parameter logic [7:0] LONG_MASK  = 8'hC0,
  parameter logic [7:0] LONG_MATCH = 8'h40,
  parameter logic [7:0] HALT_OP    = 8'h9C
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       start,
  output logic       mem_rd_en,
  output logic [7:0] mem_addr,
  input  logic [7:0] mem_rdata,
  output logic       instr_valid,
  input  logic       instr_ready,
  output logic [7:0] instr_op,
  output logic [7:0] instr_imm,
  output logic       instr_long,
  output logic [7:0] instr_pc,
  input  logic       branch_valid,
  input  logic [7:0] branch_target,
  output logic       halted,
  output logic       busy,
  output logic [7:0] retired
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_OP_REQ  = 3'd1,
    S_OP_RSP  = 3'd2,
    S_IMM_REQ = 3'd3,
    S_IMM_RSP = 3'd4,
    S_ISSUE   = 3'd5,
    S_HALTED  = 3'd6
  } state_t;

  state_t     r_state;
  state_t     w_next_state;
  logic [7:0] r_pc;
  logic [7:0] r_op;
  logic [7:0] r_imm;
  logic       r_long;
  logic [7:0] r_instr_pc;
  logic [7:0] r_retired;

  logic w_start;
  logic w_redirect;
  logic w_fire;
  logic w_rsp_long;
  logic w_is_halt;

  assign w_start    = start && (r_state == S_IDLE || r_state == S_HALTED);
  assign w_redirect = branch_valid && busy;
  // A same-cycle redirect suppresses the handshake entirely.
  assign w_fire     = (r_state == S_ISSUE) && instr_ready && !branch_valid;
  assign w_rsp_long = (mem_rdata & LONG_MASK) == LONG_MATCH;
  assign w_is_halt  = (r_op == HALT_OP) && !r_long;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    mem_rd_en    = 1'b0;
    mem_addr     = r_pc;
    instr_valid  = 1'b0;
    halted       = 1'b0;
    busy         = 1'b1;
    case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) w_next_state = S_OP_REQ;
      end
      S_OP_REQ: begin
        mem_rd_en    = 1'b1;
        w_next_state = S_OP_RSP;
      end
      S_OP_RSP:  w_next_state = w_rsp_long ? S_IMM_REQ : S_ISSUE;
      S_IMM_REQ: begin
        mem_rd_en    = 1'b1;
        mem_addr     = r_pc + 8'd1;
        w_next_state = S_IMM_RSP;
      end
      S_IMM_RSP: w_next_state = S_ISSUE;
      S_ISSUE: begin
        instr_valid = !branch_valid;
        if (w_fire) w_next_state = w_is_halt ? S_HALTED : S_OP_REQ;
      end
      S_HALTED: begin
        busy   = 1'b0;
        halted = 1'b1;
        if (start) w_next_state = S_OP_REQ;
      end
      default: w_next_state = S_IDLE;
    endcase
    if (w_redirect) w_next_state = S_OP_REQ;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_pc       <= START_PC;
      r_op       <= 8'h00;
      r_imm      <= 8'h00;
      r_long     <= 1'b0;
      r_instr_pc <= 8'h00;
      r_retired  <= 8'h00;
    end else if (w_start) begin
      r_pc <= START_PC;
    end else if (w_redirect) begin
      r_pc <= branch_target;
    end else begin
      case (r_state)
        S_OP_RSP: begin
          r_op       <= mem_rdata;
          r_instr_pc <= r_pc;
          r_long     <= w_rsp_long;
          if (!w_rsp_long) r_imm <= 8'h00;
        end
        S_IMM_RSP: r_imm <= mem_rdata;
        S_ISSUE: begin
          if (w_fire) begin
            r_retired <= r_retired + 8'd1;
            if (!w_is_halt) r_pc <= r_pc + (r_long ? 8'd2 : 8'd1);
          end
        end
        default: ;
      endcase
    end
  end

  assign instr_op   = r_op;
  assign instr_imm  = r_imm;
  assign instr_long = r_long;
  assign instr_pc   = r_instr_pc;
  assign retired    = r_retired;

endmodule
`default_nettype wire
